// File: rtl/brcomp_pkg.sv
// brcomp_pkg: shared funct3 codes, FSM states and branch-decision helper for brcomp_seq.
package brcomp_pkg;
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, DONE} brcomp_state_e;
  // funct3[0] inverts the base condition; funct3[2] picks lt over eq; 010/011 never take
  function automatic logic br_taken(input logic [2:0] op, input logic eq, input logic lt);
    return op[2] ? (lt ^ op[0]) : (op[1] ? 1'b0 : (eq ^ op[0]));
  endfunction
  function automatic logic br_illegal(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction
endpackage

// File: rtl/brcomp_chunk.sv
// brcomp_chunk: combinational unsigned equal/less-than on one CHUNK-bit slice.
module brcomp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             chunk_eq,
  output logic             chunk_lt
);
  assign chunk_eq = a == b;
  assign chunk_lt = a < b;
endmodule

// File: rtl/brcomp_seq.sv
// brcomp_seq: multi-cycle RV32I branch comparator, CHUNK bits per beat, LSB chunk first.
module brcomp_seq
  import brcomp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             kill_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic [2:0]       br_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             BrL_o,
  output logic             BrE_o,
  output logic             taken_o,
  output logic             illegal_o
);
  localparam int NBEATS = WIDTH / CHUNK;
  localparam int BW = NBEATS > 1 ? $clog2(NBEATS) : 1;
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("brcomp_seq: WIDTH must be a multiple of CHUNK");
  end
  brcomp_state_e state, state_n;
  logic [BW-1:0] beat;
  logic [WIDTH-1:0] a, b, flip;
  logic [2:0] op;
  logic eq, lt, eq_n, lt_n, chunk_eq, chunk_lt, last, accept;
  logic [IW-1:0] base;
  // signed ops bias the sign bit so one unsigned compare serves both
  assign flip = {br_op_i[2:1] == 2'b10, {(WIDTH-1){1'b0}}};
  assign accept = state == IDLE && in_valid_i && !kill_i;
  assign last = beat == BW'(NBEATS - 1);
  assign base = IW'(beat) * IW'(CHUNK);
  assign eq_n = eq & chunk_eq;
  assign lt_n = chunk_lt | (chunk_eq & lt);
  assign in_ready_o = state == IDLE;
  assign out_valid_o = state == DONE;
  brcomp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a[base +: CHUNK]),
    .b        (b[base +: CHUNK]),
    .chunk_eq (chunk_eq),
    .chunk_lt (chunk_lt)
  );
  always_comb begin
    state_n = state;
    if (kill_i) state_n = IDLE;
    else if (state == IDLE && in_valid_i) state_n = RUN;
    else if (state == RUN && last) state_n = DONE;
    else if (state == DONE && out_ready_i) state_n = IDLE;
  end
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  always_ff @(posedge clk_i) begin
    if (rst_i || kill_i) begin
      beat      <= '0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      eq        <= 1'b1;
      lt        <= 1'b0;
      BrL_o     <= 1'b0;
      BrE_o     <= 1'b0;
      taken_o   <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      if (accept) begin
        a    <= rs1_data_i ^ flip;
        b    <= rs2_data_i ^ flip;
        op   <= br_op_i;
        eq   <= 1'b1;
        lt   <= 1'b0;
        beat <= '0;
      end
      if (state == RUN) begin
        eq   <= eq_n;
        lt   <= lt_n;
        beat <= last ? '0 : beat + 1'b1;
        if (last) begin
          BrL_o     <= lt_n;
          BrE_o     <= eq_n;
          taken_o   <= br_taken(op, eq_n, lt_n);
          illegal_o <= br_illegal(op);
        end
      end
      if (state == DONE && out_ready_i) begin
        BrL_o     <= 1'b0;
        BrE_o     <= 1'b0;
        taken_o   <= 1'b0;
        illegal_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_brcomp_seq.sv
// tb_brcomp_seq: directed + random checks of brcomp_seq (CHUNK=8 and CHUNK=32) against an arithmetic model.
module tb_brcomp_seq;
  logic clk = 1'b0;
  logic rst, kill, iv8, iv32, or8, or32;
  logic [31:0] a, b;
  logic [2:0] op;
  logic ir8, ov8, l8, e8, t8, il8;
  logic ir32, ov32, l32, e32, t32, il32;
  logic ir, ov;
  logic [3:0] res;
  int sel = 0;
  int tests = 0;
  int failed = 0;
  always #5 clk = ~clk;
  brcomp_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk_i(clk), .rst_i(rst), .kill_i(kill), .in_valid_i(iv8), .in_ready_o(ir8),
    .rs1_data_i(a), .rs2_data_i(b), .br_op_i(op), .out_valid_o(ov8), .out_ready_i(or8),
    .BrL_o(l8), .BrE_o(e8), .taken_o(t8), .illegal_o(il8)
  );
  brcomp_seq #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .kill_i(kill), .in_valid_i(iv32), .in_ready_o(ir32),
    .rs1_data_i(a), .rs2_data_i(b), .br_op_i(op), .out_valid_o(ov32), .out_ready_i(or32),
    .BrL_o(l32), .BrE_o(e32), .taken_o(t32), .illegal_o(il32)
  );
  assign ir = sel != 0 ? ir32 : ir8;
  assign ov = sel != 0 ? ov32 : ov8;
  assign res = sel != 0 ? {l32, e32, t32, il32} : {l8, e8, t8, il8};
  // returns {BrL, BrE, taken, illegal}
  function automatic logic [3:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic lt, e, tk;
    lt = (f == 3'b100 || f == 3'b101) ? ($signed(x) < $signed(y)) : (x < y);
    e = x == y;
    case (f)
      3'b000: tk = e;
      3'b001: tk = !e;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default: tk = 1'b0;
    endcase
    return {lt, e, tk, f == 3'b010 || f == 3'b011};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_valid(input logic v);
    if (sel != 0) iv32 = v;
    else iv8 = v;
  endtask
  task automatic start(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f);
    a = x;
    b = y;
    op = f;
    set_valid(1'b1);
    step;
    set_valid(1'b0);
  endtask
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f, input int hold);
    int lat;
    logic [3:0] exp;
    exp = model(f, x, y);
    chk("idle_in_ready", 32'(ir), 32'd1);
    or8 = 1'b0;
    or32 = 1'b0;
    start(x, y, f);
    chk("busy_in_ready", 32'(ir), 32'd0);
    lat = 0;
    while (!ov && lat < 20) begin
      step;
      lat++;
    end
    chk("latency", 32'(lat), sel != 0 ? 32'd1 : 32'd4);
    chk("result", 32'(res), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      step;
      chk("hold_valid", 32'(ov), 32'd1);
      chk("hold_result", 32'(res), 32'(exp));
      chk("hold_in_ready", 32'(ir), 32'd0);
    end
    or8 = 1'b1;
    or32 = 1'b1;
    step;
    or8 = 1'b0;
    or32 = 1'b0;
    chk("release_valid", 32'(ov), 32'd0);
    chk("release_in_ready", 32'(ir), 32'd1);
    chk("release_zero", 32'(res), 32'd0);
  endtask
  initial begin
    int lat;
    logic [31:0] x, y;
    rst = 1'b1; kill = 1'b0; iv8 = 1'b0; iv32 = 1'b0; or8 = 1'b0; or32 = 1'b0;
    a = '0; b = '0; op = '0;
    step;
    step;
    rst = 1'b0;
    chk("reset_in_ready8", 32'(ir8), 32'd1);
    chk("reset_in_ready32", 32'(ir32), 32'd1);
    chk("reset_outs8", 32'({ov8, l8, e8, t8, il8}), 32'd0);
    chk("reset_outs32", 32'({ov32, l32, e32, t32, il32}), 32'd0);
    sel = 0;
    run_op(32'h5, 32'h5, 3'b000, 0);
    run_op(32'hFFFFFFFF, 32'h1, 3'b100, 0);
    run_op(32'hFFFFFFFF, 32'h1, 3'b110, 0);
    run_op(32'hFFFFFFFF, 32'h1, 3'b111, 1);
    run_op(32'h12345678, 32'h12345679, 3'b001, 3);
    chk("bne_taken_direct", 32'(model(3'b001, 32'h12345678, 32'h12345679)), 32'b1010);
    // kill at RUN beat 2
    start(32'h1, 32'h2, 3'b110);
    step;
    step;
    kill = 1'b1;
    step;
    kill = 1'b0;
    chk("kill_run_valid", 32'(ov8), 32'd0);
    chk("kill_run_in_ready", 32'(ir8), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step;
      chk("kill_no_result", 32'(ov8), 32'd0);
    end
    kill = 1'b1;
    start(32'h1, 32'h2, 3'b110);
    kill = 1'b0;
    chk("kill_idle_no_accept", 32'(ir8), 32'd1);
    step;
    chk("kill_idle_still_ready", 32'(ir8), 32'd1);
    run_op(32'h80000000, 32'h0, 3'b101, 0);
    // kill while DONE with out_ready: result dropped
    start(32'h3, 32'h3, 3'b000);
    lat = 0;
    while (!ov8 && lat < 20) begin
      step;
      lat++;
    end
    chk("kill_done_reached", 32'(ov8), 32'd1);
    kill = 1'b1;
    or8 = 1'b1;
    step;
    kill = 1'b0;
    or8 = 1'b0;
    chk("kill_done_valid", 32'(ov8), 32'd0);
    chk("kill_done_zero", 32'({l8, e8, t8, il8}), 32'd0);
    chk("kill_done_in_ready", 32'(ir8), 32'd1);
    // reset mid-RUN
    start(32'h9, 32'h9, 3'b000);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_mid_outs", 32'({ov8, l8, e8, t8, il8}), 32'd0);
    chk("rst_mid_in_ready", 32'(ir8), 32'd1);
    run_op(32'h10, 32'h20, 3'b011, 0);
    sel = 1;
    run_op(32'h7, 32'h9, 3'b110, 0);
    run_op(32'h80000000, 32'h1, 3'b100, 1);
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = x ^ (32'h1 << $urandom_range(0, 31));
        2: y = {x[31:8], 8'($urandom)};
        default: y = $urandom;
      endcase
      run_op(x, y, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
